// File: rtl/msrv32_pkg.sv
// Shared MSRV32 constants: register-file geometry, x0 index and write-back mux select codes.
// The optional same-cycle write-through is enabled by defining MSRV32_RF_BYPASS_EN.
package msrv32_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = $clog2(NREGS);

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    WB_ALU      = 3'd0,
    WB_LOAD     = 3'd1,
    WB_IMM      = 3'd2,
    WB_IADDER   = 3'd3,
    WB_CSR      = 3'd4,
    WB_PC_PLUS4 = 3'd5
  } wb_sel_e;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    reg_onehot    = '0;
    reg_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/msrv32_scoreboard.sv
// Per-register busy tracking and RAW stall generation for the MSRV32 register file.
// With MSRV32_RF_BYPASS_EN a write-back to the same register resolves the stall that cycle.
module msrv32_scoreboard
  import msrv32_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              i_commit,
  input  logic [ADDR_W-1:0] i_commit_addr,
  input  logic              i_flush,
  input  logic              i_issue_valid,
  input  logic              i_issue_rd_wr,
  input  logic [ADDR_W-1:0] i_issue_rd_addr,
  input  logic [ADDR_W-1:0] i_rs_1_addr,
  input  logic [ADDR_W-1:0] i_rs_2_addr,
  output logic              o_hazard_stall
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_busy_next;
  logic             w_res_1;
  logic             w_res_2;
  logic             w_stall_1;
  logic             w_stall_2;

`ifdef MSRV32_RF_BYPASS_EN
  assign w_res_1 = i_commit & (i_commit_addr == i_rs_1_addr);
  assign w_res_2 = i_commit & (i_commit_addr == i_rs_2_addr);
`else
  assign w_res_1 = 1'b0;
  assign w_res_2 = 1'b0;
`endif

  assign w_stall_1      = r_busy[i_rs_1_addr] & (i_rs_1_addr != REG_ZERO) & ~w_res_1;
  assign w_stall_2      = r_busy[i_rs_2_addr] & (i_rs_2_addr != REG_ZERO) & ~w_res_2;
  assign o_hazard_stall = w_stall_1 | w_stall_2;

  // Set is applied after clear so a same-cycle reissue of the committing rd stays busy.
  assign w_clr = i_commit ? reg_onehot(i_commit_addr) : '0;
  assign w_set = (i_issue_valid & i_issue_rd_wr & ~o_hazard_stall & (i_issue_rd_addr != REG_ZERO))
               ? reg_onehot(i_issue_rd_addr) : '0;
  assign w_busy_next = ((r_busy & ~w_clr) | w_set) & ~reg_onehot(REG_ZERO);

  // Busy vector; flush wipes every entry ahead of any issue.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy <= '0;
    end else if (i_flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

endmodule

// File: rtl/msrv32_integer_file_wb.sv
// MSRV32 write-back stage: 32x32 integer register file, two combinational read ports, busy
// scoreboard and commit flag. Define MSRV32_RF_BYPASS_EN for same-cycle write-through reads.
module msrv32_integer_file_wb
  import msrv32_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              wb_valid_in,
  input  logic              wb_rf_wr_en_in,
  input  logic [ADDR_W-1:0] wb_rd_addr_in,
  input  logic [XLEN-1:0]   wb_data_in,
  input  logic              flush_in,
  input  logic              issue_valid_in,
  input  logic              issue_rd_wr_in,
  input  logic [ADDR_W-1:0] issue_rd_addr_in,
  input  logic [ADDR_W-1:0] rs_1_addr_in,
  input  logic [ADDR_W-1:0] rs_2_addr_in,
  output logic [XLEN-1:0]   rs_1_out,
  output logic [XLEN-1:0]   rs_2_out,
  output logic              hazard_stall_out,
  output logic              wb_commit_out
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_commit;
  logic            w_commit;
  logic            w_byp_1;
  logic            w_byp_2;

  assign w_commit = wb_valid_in & wb_rf_wr_en_in & ~flush_in & (wb_rd_addr_in != REG_ZERO);

`ifdef MSRV32_RF_BYPASS_EN
  assign w_byp_1 = w_commit & (wb_rd_addr_in == rs_1_addr_in);
  assign w_byp_2 = w_commit & (wb_rd_addr_in == rs_2_addr_in);
`else
  assign w_byp_1 = 1'b0;
  assign w_byp_2 = 1'b0;
`endif

  // Register array; x0 is excluded by the commit qualifier.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[wb_rd_addr_in] <= wb_data_in;
    end
  end

  // Commit flag for the next stage.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_commit <= 1'b0;
    end else begin
      r_commit <= w_commit;
    end
  end

  assign wb_commit_out = r_commit;

  // Read ports: x0 forced to zero, optional write-through of the committing value.
  always_comb begin
    rs_1_out = '0;
    rs_2_out = '0;
    if (rs_1_addr_in == REG_ZERO) begin
      rs_1_out = '0;
    end else if (w_byp_1) begin
      rs_1_out = wb_data_in;
    end else begin
      rs_1_out = r_regs[rs_1_addr_in];
    end
    if (rs_2_addr_in == REG_ZERO) begin
      rs_2_out = '0;
    end else if (w_byp_2) begin
      rs_2_out = wb_data_in;
    end else begin
      rs_2_out = r_regs[rs_2_addr_in];
    end
  end

  msrv32_scoreboard u_scoreboard (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .i_commit        (w_commit),
    .i_commit_addr   (wb_rd_addr_in),
    .i_flush         (flush_in),
    .i_issue_valid   (issue_valid_in),
    .i_issue_rd_wr   (issue_rd_wr_in),
    .i_issue_rd_addr (issue_rd_addr_in),
    .i_rs_1_addr     (rs_1_addr_in),
    .i_rs_2_addr     (rs_2_addr_in),
    .o_hazard_stall  (hazard_stall_out)
  );

endmodule

// File: tb/tb_msrv32_integer_file_wb.sv
// Self-checking bench for msrv32_integer_file_wb: directed scenarios then random traffic,
// compared against an array/flag reference model. Honours MSRV32_RF_BYPASS_EN.
module tb_msrv32_integer_file_wb;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        wb_valid_in;
  logic        wb_rf_wr_en_in;
  logic [4:0]  wb_rd_addr_in;
  logic [31:0] wb_data_in;
  logic        flush_in;
  logic        issue_valid_in;
  logic        issue_rd_wr_in;
  logic [4:0]  issue_rd_addr_in;
  logic [4:0]  rs_1_addr_in;
  logic [4:0]  rs_2_addr_in;
  logic [31:0] rs_1_out;
  logic [31:0] rs_2_out;
  logic        hazard_stall_out;
  logic        wb_commit_out;

`ifdef MSRV32_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  msrv32_integer_file_wb dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .wb_valid_in      (wb_valid_in),
    .wb_rf_wr_en_in   (wb_rf_wr_en_in),
    .wb_rd_addr_in    (wb_rd_addr_in),
    .wb_data_in       (wb_data_in),
    .flush_in         (flush_in),
    .issue_valid_in   (issue_valid_in),
    .issue_rd_wr_in   (issue_rd_wr_in),
    .issue_rd_addr_in (issue_rd_addr_in),
    .rs_1_addr_in     (rs_1_addr_in),
    .rs_2_addr_in     (rs_2_addr_in),
    .rs_1_out         (rs_1_out),
    .rs_2_out         (rs_2_out),
    .hazard_stall_out (hazard_stall_out),
    .wb_commit_out    (wb_commit_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: drive, check combinational outputs mid-cycle, advance, check commit.
  task automatic step(input bit wv, input bit ww, input logic [4:0] wrd, input logic [31:0] wd,
                      input bit fl, input bit iv, input bit iw, input logic [4:0] ird,
                      input logic [4:0] a1, input logic [4:0] a2, input string tag);
    bit          cm;
    bit          st;
    logic [31:0] e1;
    logic [31:0] e2;
    wb_valid_in      = wv;
    wb_rf_wr_en_in   = ww;
    wb_rd_addr_in    = wrd;
    wb_data_in       = wd;
    flush_in         = fl;
    issue_valid_in   = iv;
    issue_rd_wr_in   = iw;
    issue_rd_addr_in = ird;
    rs_1_addr_in     = a1;
    rs_2_addr_in     = a2;
    cm = wv && ww && !fl && (wrd != 5'd0);
    e1 = (a1 == 5'd0) ? 32'd0 : ((BYP && cm && wrd == a1) ? wd : m_regs[a1]);
    e2 = (a2 == 5'd0) ? 32'd0 : ((BYP && cm && wrd == a2) ? wd : m_regs[a2]);
    st = (m_busy[a1] && a1 != 5'd0 && !(BYP && cm && wrd == a1)) ||
         (m_busy[a2] && a2 != 5'd0 && !(BYP && cm && wrd == a2));
    #3;
    chk({tag, ".rs1"}, rs_1_out, e1);
    chk({tag, ".rs2"}, rs_2_out, e2);
    chk({tag, ".stall"}, {31'd0, hazard_stall_out}, {31'd0, st});
    @(posedge clk_in);
    #1;
    if (cm) m_regs[wrd] = wd;
    if (fl) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (cm) m_busy[wrd] = 1'b0;
      if (iv && iw && !st && ird != 5'd0) m_busy[ird] = 1'b1;
    end
    chk({tag, ".commit"}, {31'd0, wb_commit_out}, {31'd0, cm});
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, a1, a2, tag);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] a1,
                    input logic [4:0] a2, input string tag);
    step(1'b1, 1'b1, rd, d, 1'b0, 1'b0, 1'b0, 5'd0, a1, a2, tag);
  endtask

  task automatic iss(input logic [4:0] rd, input string tag);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, rd, 5'd0, 5'd0, tag);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    else return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_in = 1'b1;
    wb_valid_in = 1'b0; wb_rf_wr_en_in = 1'b0; wb_rd_addr_in = 5'd0; wb_data_in = 32'd0;
    flush_in = 1'b0; issue_valid_in = 1'b0; issue_rd_wr_in = 1'b0; issue_rd_addr_in = 5'd0;
    rs_1_addr_in = 5'd5; rs_2_addr_in = 5'd31;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst.rs1", rs_1_out, 32'd0);
    chk("rst.rs2", rs_2_out, 32'd0);
    chk("rst.stall", {31'd0, hazard_stall_out}, 32'd0);
    chk("rst.commit", {31'd0, wb_commit_out}, 32'd0);
    rst_in = 1'b0;

    // Reset mid-run
    wr(5'd5, 32'hDEADBEEF, 5'd5, 5'd0, "t1.wr");
    iss(5'd5, "t1.iss");
    rs_1_addr_in = 5'd5;
    #2;
    chk("t1.busy_before", {31'd0, hazard_stall_out}, {31'd0, m_busy[5]});
    chk("t1.val_before", rs_1_out, 32'hDEADBEEF);
    rst_in = 1'b1;
    #1;
    model_reset();
    chk("t1.rs1_async", rs_1_out, 32'd0);
    chk("t1.stall_async", {31'd0, hazard_stall_out}, 32'd0);
    chk("t1.commit_async", {31'd0, wb_commit_out}, 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    // Write to x0 is dropped
    wr(5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "t2.wr0");
    idle(5'd0, 5'd0, "t2.rd0");

    // RAW on x7
    iss(5'd7, "t3.iss");
    idle(5'd7, 5'd0, "t3.wait");
    wr(5'd7, 32'h12345678, 5'd7, 5'd0, "t3.wb");
    idle(5'd7, 5'd0, "t3.after");
    chk("t3.value", rs_1_out, 32'h12345678);

    // Commit and reissue of x9 in the same cycle
    iss(5'd9, "t4.iss");
    step(1'b1, 1'b1, 5'd9, 32'h00000099, 1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, "t4.coll");
    idle(5'd9, 5'd0, "t4.busy");

    // Flush with a pending beat to x3
    iss(5'd3, "t5.iss3");
    iss(5'd4, "t5.iss4");
    step(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd4, "t5.flush");
    idle(5'd3, 5'd4, "t5.after");
    idle(5'd9, 5'd7, "t5.other");

    // Both read ports
    wr(5'd31, 32'h00000001, 5'd0, 5'd0, "t6.wr31");
    wr(5'd1, 32'h00000002, 5'd31, 5'd0, "t6.wr1");
    idle(5'd31, 5'd1, "t6.rd");
    chk("t6.rs1_val", rs_1_out, 32'h00000001);
    chk("t6.rs2_val", rs_2_out, 32'h00000002);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), rnd_addr(), $urandom(),
           ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           rnd_addr(), rnd_addr(), rnd_addr(), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
